// File: rtl/ddr_burst_arbiter.sv
// Arbitrates the single ddr_controller rd/wr burst port among ins refill, data refill, jump fetch and store.
// Define ARB_RR_EN for round-robin among the three read requesters (store always wins).
module ddr_burst_arbiter #(
   parameter int DDR_ADDR_WIDTH = 28,
   parameter int MAX_BURST_LEN  = 256,
   parameter int BEAT_CNT_WIDTH = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      init_calib_complete,
   input  logic                      ins_read_req,
   input  logic [DDR_ADDR_WIDTH-1:0] ins_read_addr,
   input  logic [7:0]                ins_read_len,
   input  logic                      ddr_to_ic_fifo_empty,
   input  logic                      data_read_req,
   input  logic                      jmp_addr_read_req,
   input  logic [DDR_ADDR_WIDTH-1:0] data_read_addr,
   input  logic [BEAT_CNT_WIDTH-1:0] data_read_len,
   input  logic                      ddr_to_dc_fifo_empty,
   input  logic                      data_store_req,
   input  logic [DDR_ADDR_WIDTH-1:0] data_write_addr,
   input  logic [BEAT_CNT_WIDTH-1:0] wr_data_cnt,
   output logic                      rd_burst_req,
   output logic                      wr_burst_req,
   output logic [BEAT_CNT_WIDTH-1:0] rd_burst_len,
   output logic [BEAT_CNT_WIDTH-1:0] wr_burst_len,
   output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
   output logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
   input  logic                      rd_burst_data_valid,
   input  logic                      rd_burst_finish,
   input  logic                      wr_burst_finish,
   output logic                      ins_reading,
   output logic                      data_reading,
   output logic                      jmp_reading,
   output logic                      data_storing,
   output logic                      ins_done,
   output logic                      data_done,
   output logic                      jmp_done,
   output logic                      store_done,
   output logic [1:0]                grant_id,
   output logic                      len_err,
   output logic [1:0]                fsm_state
);

   localparam logic [BEAT_CNT_WIDTH-1:0] MAX_LEN = BEAT_CNT_WIDTH'(MAX_BURST_LEN);
   localparam logic [1:0] ID_INS   = 2'd0;
   localparam logic [1:0] ID_DATA  = 2'd1;
   localparam logic [1:0] ID_JMP   = 2'd2;
   localparam logic [1:0] ID_STORE = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_BUSY = 2'd1,
      WR_BUSY = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic                      ins_elig, data_elig, jmp_elig, store_elig, any_elig;
   logic                      take_grant;
   logic [1:0]                grant_sel;
   logic [BEAT_CNT_WIDTH-1:0] sel_len;
   logic [DDR_ADDR_WIDTH-1:0] sel_addr;
   logic [1:0]                owner_q;
   logic                      zero_len_q;
   logic [BEAT_CNT_WIDTH-1:0] beat_cnt;
   logic [BEAT_CNT_WIDTH:0]   beat_total;
   logic                      busy_any, done_any;

   function automatic logic [BEAT_CNT_WIDTH-1:0] clamp_len(input logic [BEAT_CNT_WIDTH-1:0] len);
      return (len > MAX_LEN) ? MAX_LEN : len;
   endfunction

   // Reads may only start when the destination FIFO has fully drained.
   assign ins_elig   = ins_read_req      & ddr_to_ic_fifo_empty;
   assign data_elig  = data_read_req     & ddr_to_dc_fifo_empty;
   assign jmp_elig   = jmp_addr_read_req & ddr_to_dc_fifo_empty;
   assign store_elig = data_store_req;
   assign any_elig   = ins_elig | data_elig | jmp_elig | store_elig;
   assign take_grant = (state == IDLE) & init_calib_complete & any_elig;

`ifdef ARB_RR_EN
   logic [1:0] rr_last;

   // Search begins at the read requester after the one granted last.
   always_comb begin
      grant_sel = ID_INS;
      if (store_elig) begin
         grant_sel = ID_STORE;
      end else begin
         case (rr_last)
            ID_INS: begin
               if (data_elig)     grant_sel = ID_DATA;
               else if (jmp_elig) grant_sel = ID_JMP;
               else               grant_sel = ID_INS;
            end
            ID_DATA: begin
               if (jmp_elig)      grant_sel = ID_JMP;
               else if (ins_elig) grant_sel = ID_INS;
               else               grant_sel = ID_DATA;
            end
            default: begin
               if (ins_elig)       grant_sel = ID_INS;
               else if (data_elig) grant_sel = ID_DATA;
               else                grant_sel = ID_JMP;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_last <= ID_INS;
      end else if (take_grant && (grant_sel != ID_STORE)) begin
         rr_last <= grant_sel;
      end
   end
`else
   always_comb begin
      grant_sel = ID_INS;
      if (store_elig)     grant_sel = ID_STORE;
      else if (jmp_elig)  grant_sel = ID_JMP;
      else if (data_elig) grant_sel = ID_DATA;
      else                grant_sel = ID_INS;
   end
`endif

   always_comb begin
      sel_len  = '0;
      sel_addr = '0;
      case (grant_sel)
         ID_INS: begin
            sel_len  = clamp_len(BEAT_CNT_WIDTH'(ins_read_len));
            sel_addr = ins_read_addr;
         end
         ID_DATA: begin
            sel_len  = clamp_len(data_read_len);
            sel_addr = data_read_addr;
         end
         ID_JMP: begin
            sel_len  = BEAT_CNT_WIDTH'(1);
            sel_addr = data_read_addr;
         end
         default: begin
            sel_len  = clamp_len(wr_data_cnt);
            sel_addr = data_write_addr;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Burst handshake: rd/wr_burst_req is held high with address and length stable until the
   // controller returns a one-cycle *_burst_finish; a finish seen outside the busy states is ignored.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (take_grant) begin
               if (sel_len == '0)              state_nxt = DONE;
               else if (grant_sel == ID_STORE) state_nxt = WR_BUSY;
               else                            state_nxt = RD_BUSY;
            end
         end
         RD_BUSY: if (rd_burst_finish) state_nxt = DONE;
         WR_BUSY: if (wr_burst_finish) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rd_burst_req = (state == RD_BUSY);
      wr_burst_req = (state == WR_BUSY);
      // A zero-length grant shows busy only during its DONE cycle.
      busy_any     = (state == RD_BUSY) | (state == WR_BUSY) | ((state == DONE) & zero_len_q);
      done_any     = (state == DONE);
      ins_reading  = busy_any & (owner_q == ID_INS);
      data_reading = busy_any & (owner_q == ID_DATA);
      jmp_reading  = busy_any & (owner_q == ID_JMP);
      data_storing = busy_any & (owner_q == ID_STORE);
      ins_done     = done_any & (owner_q == ID_INS);
      data_done    = done_any & (owner_q == ID_DATA);
      jmp_done     = done_any & (owner_q == ID_JMP);
      store_done   = done_any & (owner_q == ID_STORE);
      grant_id     = owner_q;
      fsm_state    = state;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q       <= ID_INS;
         zero_len_q    <= 1'b0;
         rd_burst_addr <= '0;
         rd_burst_len  <= '0;
         wr_burst_addr <= '0;
         wr_burst_len  <= '0;
      end else if (take_grant) begin
         owner_q    <= grant_sel;
         zero_len_q <= (sel_len == '0);
         if (grant_sel == ID_STORE) begin
            wr_burst_addr <= sel_addr;
            wr_burst_len  <= sel_len;
         end else begin
            rd_burst_addr <= sel_addr;
            rd_burst_len  <= sel_len;
         end
      end
   end

   // A beat arriving together with finish still belongs to the burst.
   assign beat_total = {1'b0, beat_cnt} + (BEAT_CNT_WIDTH+1)'(rd_burst_data_valid);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_cnt <= '0;
         len_err  <= 1'b0;
      end else begin
         if (state == DONE) begin
            beat_cnt <= '0;
         end else if ((state == RD_BUSY) && rd_burst_data_valid && (beat_cnt != '1)) begin
            beat_cnt <= beat_cnt + BEAT_CNT_WIDTH'(1);
         end
         if ((state == RD_BUSY) && rd_burst_finish && (beat_total != {1'b0, rd_burst_len})) begin
            len_err <= 1'b1;
         end
      end
   end

endmodule
